// File: rtl/mem_write_m2.sv
// Result write side: per-bank address counters absorb the systolic skew and
// fill N result BRAM banks. Optional overflow flag under MEM_WRITE_OVF_CHECK_EN.
module mem_write_m2 #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned N     = 3,
  parameter int unsigned M     = 6,
  parameter int unsigned ACC_W = 2*D_W + $clog2(M),
  localparam int unsigned WORDS = M*M/N,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     valid_in,
  input  logic [ACC_W-1:0] data_in      [N-1:0],
  output logic [N-1:0]     wr_en_bram,
  output logic [AW-1:0]    wr_addr_bram [N-1:0],
  output logic [ACC_W-1:0] wr_data_bram [N-1:0],
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt [N-1:0];
  logic [N-1:0]    full;
  logic [N-1:0]    wr_c;
  logic [N-1:0]    fill_c;

  // Next state and per-bank write qualification; start always takes priority.
  always_comb begin
    state_nxt = state;
    wr_c      = '0;
    fill_c    = '0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (!start) begin
          for (int unsigned x = 0; x < N; x++) begin
            if (valid_in[x] && !full[x]) begin
              wr_c[x]   = 1'b1;
              fill_c[x] = (cnt[x] == AW'(WORDS-1));
            end
          end
          if (&(full | fill_c)) state_nxt = DONE;
        end
      end
      DONE: if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write port registers, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_bram <= '0;
      full       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int unsigned x = 0; x < N; x++) begin
        cnt[x]          <= '0;
        wr_addr_bram[x] <= '0;
        wr_data_bram[x] <= '0;
      end
    end else begin
      wr_en_bram <= wr_c;
      busy       <= (state_nxt == RUN);
      done       <= (state_nxt == DONE);
      if (start) begin
        full <= '0;
        for (int unsigned x = 0; x < N; x++) cnt[x] <= '0;
      end else begin
        for (int unsigned x = 0; x < N; x++) begin
          if (wr_c[x]) begin
            // A bank that just wrote its last word holds its count.
            if (fill_c[x]) full[x] <= 1'b1;
            else           cnt[x]  <= cnt[x] + AW'(1);
          end
        end
      end
      for (int unsigned x = 0; x < N; x++) begin
        if (wr_c[x]) begin
          wr_addr_bram[x] <= cnt[x];
          wr_data_bram[x] <= data_in[x];
        end
      end
    end
  end

`ifdef MEM_WRITE_OVF_CHECK_EN
  logic ovf_c;

  // Overflow: valid on an already-full bank in RUN, or any valid in DONE.
  always_comb begin
    ovf_c = 1'b0;
    if (!start) begin
      if (state == RUN)  ovf_c = |(valid_in & full);
      if (state == DONE) ovf_c = |valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) err <= 1'b0;
    else if (ovf_c)   err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
